// File: rtl/seq_mul_param.sv
// rtl/seq_mul_param.sv - iterative shift-and-add multiplier, unsigned or two's-complement, valid/ready on both sides
module seq_mul_param #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic                 CLK_0,
  input  logic                 RST_0,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 signed_mode,
  input  logic [WIDTH-1:0]     A_0,
  input  logic [WIDTH-1:0]     B_0,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   P_0,
  output logic [WIDTH-1:0]     out_A
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [CNT_W-1:0]   cnt;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] mcand;
  logic [WIDTH-1:0]   mplier;
  logic [WIDTH-1:0]   a_cap;
  logic               neg;

  logic               accept;
  logic               last;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic [2*WIDTH-1:0] acc_sum;
  logic [2*WIDTH-1:0] prod;

  always_ff @(posedge CLK_0) begin
    if (RST_0) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          accept    = 1'b1;
          state_nxt = CALC;
        end
      end
      CALC: begin
        if (cnt == CNT_W'(1)) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // -2^(WIDTH-1) negates to itself, which read as unsigned is exactly its magnitude.
  always_comb begin
    a_mag   = (signed_mode && A_0[WIDTH-1]) ? -A_0 : A_0;
    b_mag   = (signed_mode && B_0[WIDTH-1]) ? -B_0 : B_0;
    acc_sum = acc + (mplier[0] ? mcand : '0);
    prod    = neg ? -acc_sum : acc_sum;
    last    = (state == CALC) && (cnt == CNT_W'(1));
  end

  always_ff @(posedge CLK_0) begin
    if (RST_0) begin
      cnt    <= '0;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      a_cap  <= '0;
      neg    <= 1'b0;
      P_0    <= '0;
      out_A  <= '0;
    end else begin
      if (accept) begin
        cnt    <= CNT_W'(WIDTH);
        acc    <= '0;
        mcand  <= {{WIDTH{1'b0}}, a_mag};
        mplier <= b_mag;
        a_cap  <= A_0;
        neg    <= signed_mode & (A_0[WIDTH-1] ^ B_0[WIDTH-1]);
      end else if (state == CALC) begin
        acc    <= acc_sum;
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
        cnt    <= cnt - CNT_W'(1);
      end
      // A zero magnitude stays zero under negation, so no special case is needed.
      if (last) begin
        P_0   <= prod;
        out_A <= a_cap;
      end
    end
  end

endmodule
